deskew_ctrl_fsm: RTL and testbench

//  Parametrised deskew controller for the multi-lane RX path; sits between the per-lane AM lock/

---
 rtl/deskew_ctrl_fsm.sv | 179 +++++++++++++++++
 tb/tb_deskew_ctrl_fsm.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/deskew_ctrl_fsm.sv
// Multi-lane RX deskew controller: measures per-lane AM arrival skew,
// programs per-lane FIFO delays, and monitors post-deskew alignment.
//
// Ports:
//   i_clock, i_reset (async, active-low)
//   i_enable, i_valid   - state advances only when both are high
//   i_resync, i_am_lock - synchronous restart / loss of lock -> IDLE
//   i_start_of_lane     - per-lane AM pulse before deskew
//   i_post_am           - per-lane AM pulse at the FIFO output
//   o_lane_delay        - lane k delay at [k*NB +: NB]
//   o_skew              - measured skew (last arrival time)
//   o_set_fifo_delay    - 1-cycle load strobe for the FIFOs
//   o_write_fifo_enb    - FIFO write enable
//   o_read_fifo_enb     - FIFO read enable
//   o_lanes_arrived     - arrival mask of the current measurement
//   o_deskew_done       - level: alignment established
//   o_invalid_skew      - 1-cycle pulse: skew out of range
//   o_realign           - 1-cycle pulse: persistent misalignment
module deskew_ctrl_fsm #(
  parameter int N_LANES        = 20,
  parameter int MAX_SKEW       = 16,
  parameter int NB_DELAY_COUNT = $clog2(MAX_SKEW),
  parameter bit VERIFY_EN      = 1'b1,
  parameter int MAX_ERR        = 3
) (
  input  logic                              i_clock,
  input  logic                              i_reset,
  input  logic                              i_enable,
  input  logic                              i_valid,
  input  logic                              i_resync,
  input  logic                              i_am_lock,
  input  logic [N_LANES-1:0]                i_start_of_lane,
  input  logic [N_LANES-1:0]                i_post_am,
  output logic [N_LANES*NB_DELAY_COUNT-1:0] o_lane_delay,
  output logic [NB_DELAY_COUNT-1:0]         o_skew,
  output logic                              o_set_fifo_delay,
  output logic                              o_write_fifo_enb,
  output logic                              o_read_fifo_enb,
  output logic [N_LANES-1:0]                o_lanes_arrived,
  output logic                              o_deskew_done,
  output logic                              o_invalid_skew,
  output logic                              o_realign
);

  localparam int NB    = NB_DELAY_COUNT;
  localparam int ERR_W = $clog2(MAX_ERR + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_LOAD,
    S_LOCKED
  } state_t;

  state_t             state;
  logic [N_LANES-1:0] mask;
  logic [NB-1:0]      cnt;
  logic [ERR_W-1:0]   err;
  logic [NB-1:0]      arrival [N_LANES];

  logic [N_LANES-1:0] new_lanes;
  logic [ERR_W-1:0]   err_inc;
  logic               post_full;
  logic               post_part;

  // Only first arrivals count; repeat pulses from lanes
  // already in the mask are ignored.
  always_comb begin
    new_lanes = i_start_of_lane & ~mask;
    err_inc   = err + 1'b1;
    post_full = &i_post_am;
    post_part = (|i_post_am) & ~post_full;
  end

  assign o_lanes_arrived = mask;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state            <= S_IDLE;
      mask             <= '0;
      cnt              <= '0;
      err              <= '0;
      o_lane_delay     <= '0;
      o_skew           <= '0;
      o_set_fifo_delay <= 1'b0;
      o_write_fifo_enb <= 1'b0;
      o_read_fifo_enb  <= 1'b0;
      o_deskew_done    <= 1'b0;
      o_invalid_skew   <= 1'b0;
      o_realign        <= 1'b0;
      for (int k = 0; k < N_LANES; k++)
        arrival[k] <= '0;
    end else begin
      o_set_fifo_delay <= 1'b0;
      o_invalid_skew   <= 1'b0;
      o_realign        <= 1'b0;
      if (i_resync || !i_am_lock) begin
        state            <= S_IDLE;
        mask             <= '0;
        cnt              <= '0;
        err              <= '0;
        o_write_fifo_enb <= 1'b0;
        o_read_fifo_enb  <= 1'b0;
        o_deskew_done    <= 1'b0;
      end else if (i_enable && i_valid) begin
        unique case (state)
          S_IDLE: begin
            if (|i_start_of_lane) begin
              mask             <= i_start_of_lane;
              cnt              <= NB'(1);
              o_write_fifo_enb <= 1'b1;
              for (int k = 0; k < N_LANES; k++)
                if (i_start_of_lane[k])
                  arrival[k] <= '0;
              if (&i_start_of_lane) begin
                state  <= S_LOAD;
                o_skew <= '0;
              end else begin
                state <= S_COUNT;
              end
            end
          end
          S_COUNT: begin
            for (int k = 0; k < N_LANES; k++)
              if (new_lanes[k])
                arrival[k] <= cnt;
            if (&(mask | new_lanes)) begin
              mask   <= mask | new_lanes;
              state  <= S_LOAD;
              o_skew <= cnt;
            end else if (cnt == NB'(MAX_SKEW - 1)) begin
              mask             <= '0;
              cnt              <= '0;
              state            <= S_IDLE;
              o_invalid_skew   <= 1'b1;
              o_write_fifo_enb <= 1'b0;
            end else begin
              mask <= mask | new_lanes;
              cnt  <= cnt + 1'b1;
            end
          end
          S_LOAD: begin
            // Last arrival is o_skew, so no lane delay underflows.
            for (int k = 0; k < N_LANES; k++)
              o_lane_delay[k*NB +: NB] <= o_skew - arrival[k];
            o_set_fifo_delay <= 1'b1;
            o_write_fifo_enb <= 1'b1;
            o_read_fifo_enb  <= 1'b1;
            o_deskew_done    <= 1'b1;
            cnt              <= '0;
            err              <= '0;
            state            <= S_LOCKED;
          end
          S_LOCKED: begin
            if (VERIFY_EN) begin
              if (post_full) begin
                err <= '0;
              end else if (post_part) begin
                if (err_inc == ERR_W'(MAX_ERR)) begin
                  err              <= '0;
                  mask             <= '0;
                  state            <= S_IDLE;
                  o_realign        <= 1'b1;
                  o_deskew_done    <= 1'b0;
                  o_write_fifo_enb <= 1'b0;
                  o_read_fifo_enb  <= 1'b0;
                end else begin
                  err <= err_inc;
                end
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_deskew_ctrl_fsm.sv
// Directed bench for deskew_ctrl_fsm with 4 lanes,
// MAX_SKEW=16, MAX_ERR=3.
module tb_deskew_ctrl_fsm;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        vld;
  logic        resync;
  logic        lock;
  logic [3:0]  sol;
  logic [3:0]  post;
  logic [15:0] delay;
  logic [3:0]  skew;
  logic        set_d;
  logic        wr;
  logic        rd;
  logic [3:0]  arrived;
  logic        done;
  logic        inval;
  logic        realign;

  int cmp = 0;
  int mis = 0;

  deskew_ctrl_fsm #(
    .N_LANES(4),
    .MAX_SKEW(16),
    .VERIFY_EN(1'b1),
    .MAX_ERR(3)
  ) dut (
    .i_clock(clk),
    .i_reset(rst_n),
    .i_enable(en),
    .i_valid(vld),
    .i_resync(resync),
    .i_am_lock(lock),
    .i_start_of_lane(sol),
    .i_post_am(post),
    .o_lane_delay(delay),
    .o_skew(skew),
    .o_set_fifo_delay(set_d),
    .o_write_fifo_enb(wr),
    .o_read_fifo_enb(rd),
    .o_lanes_arrived(arrived),
    .o_deskew_done(done),
    .o_invalid_skew(inval),
    .o_realign(realign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic [3:0] s,
                      input logic [3:0] p,
                      input logic v);
    sol  = s;
    post = p;
    vld  = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_resync();
    resync = 1'b1;
    step(4'h0, 4'h0, 1'b1);
    resync = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b1; vld = 1'b0; resync = 1'b0; lock = 1'b1;
    sol = '0; post = '0;
    repeat (2) @(posedge clk);
    #1;
    cmp++;
    if ({delay, skew, arrived} !== 24'h0) begin
      mis++;
      $display("FAIL rst_data got %h want 0", {delay, skew, arrived});
    end
    cmp++;
    if ({set_d, wr, rd, done, inval, realign} !== 6'b0) begin
      mis++;
      $display("FAIL rst_ctl got %b want 0",
               {set_d, wr, rd, done, inval, realign});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_skew5();
    step(4'b0001, 4'h0, 1'b1);
    cmp++;
    if (wr !== 1'b1 || arrived !== 4'b0001) begin
      mis++;
      $display("FAIL t1_start got wr=%b m=%b want 1 0001", wr, arrived);
    end
    step(4'b0000, 4'h0, 1'b1);
    step(4'b0010, 4'h0, 1'b1);
    step(4'b0000, 4'h0, 1'b1);
    step(4'b0000, 4'h0, 1'b1);
    step(4'b1100, 4'h0, 1'b1);
    cmp++;
    if (skew !== 4'd5 || arrived !== 4'hf || set_d !== 1'b0) begin
      mis++;
      $display("FAIL t1_arr got skew=%0d m=%h set=%b want 5 f 0",
               skew, arrived, set_d);
    end
    step(4'b0000, 4'h0, 1'b1);
    cmp++;
    if (set_d !== 1'b1 || delay !== 16'h0035) begin
      mis++;
      $display("FAIL t1_load got set=%b d=%h want 1 0035", set_d, delay);
    end
    cmp++;
    if ({done, wr, rd} !== 3'b111) begin
      mis++;
      $display("FAIL t1_lock got %b want 111", {done, wr, rd});
    end
    step(4'b0000, 4'h0, 1'b1);
    cmp++;
    if (set_d !== 1'b0 || done !== 1'b1) begin
      mis++;
      $display("FAIL t1_once got set=%b done=%b want 0 1", set_d, done);
    end
  endtask

  task automatic test_all_same();
    do_resync();
    cmp++;
    if (done !== 1'b0 || arrived !== 4'h0) begin
      mis++;
      $display("FAIL t2_resync got done=%b m=%h want 0 0", done, arrived);
    end
    step(4'hf, 4'h0, 1'b1);
    step(4'h0, 4'h0, 1'b1);
    cmp++;
    if (skew !== 4'd0 || delay !== 16'h0 || set_d !== 1'b1
        || done !== 1'b1) begin
      mis++;
      $display("FAIL t2_same got s=%0d d=%h set=%b done=%b want 0 0 1 1",
               skew, delay, set_d, done);
    end
  endtask

  task automatic test_invalid();
    do_resync();
    step(4'b0111, 4'h0, 1'b1);
    for (int i = 1; i < 15; i++) step(4'h0, 4'h0, 1'b1);
    cmp++;
    if (inval !== 1'b0) begin
      mis++;
      $display("FAIL t3_early got inv=%b want 0", inval);
    end
    step(4'h0, 4'h0, 1'b1);
    cmp++;
    if (inval !== 1'b1 || arrived !== 4'h0 || wr !== 1'b0) begin
      mis++;
      $display("FAIL t3_inv got inv=%b m=%h wr=%b want 1 0 0",
               inval, arrived, wr);
    end
    step(4'h0, 4'h0, 1'b1);
    cmp++;
    if (inval !== 1'b0 || set_d !== 1'b0) begin
      mis++;
      $display("FAIL t3_pulse got inv=%b set=%b want 0 0", inval, set_d);
    end
    // Last lane at the edge count 15 is still legal.
    step(4'b0111, 4'h0, 1'b1);
    for (int i = 1; i < 15; i++) step(4'h0, 4'h0, 1'b1);
    step(4'b1000, 4'h0, 1'b1);
    step(4'h0, 4'h0, 1'b1);
    cmp++;
    if (skew !== 4'd15 || delay !== 16'h0fff || set_d !== 1'b1
        || inval !== 1'b0) begin
      mis++;
      $display("FAIL t3_edge got s=%0d d=%h set=%b inv=%b want 15 0fff 1 0",
               skew, delay, set_d, inval);
    end
  endtask

  task automatic test_valid_gap();
    do_resync();
    step(4'b0001, 4'h0, 1'b1);
    step(4'b0000, 4'h0, 1'b1);
    step(4'b0010, 4'h0, 1'b1);
    step(4'b0000, 4'h0, 1'b1);
    for (int i = 0; i < 4; i++) step(4'b1100, 4'h0, 1'b0);
    en = 1'b0;
    step(4'b1100, 4'h0, 1'b1);
    en = 1'b1;
    cmp++;
    if (arrived !== 4'b0011 || skew !== 4'd15) begin
      mis++;
      $display("FAIL t4_hold got m=%b s=%0d want 0011 15", arrived, skew);
    end
    step(4'b0000, 4'h0, 1'b1);
    step(4'b1100, 4'h0, 1'b1);
    step(4'b0000, 4'h0, 1'b1);
    cmp++;
    if (skew !== 4'd5 || delay !== 16'h0035 || set_d !== 1'b1) begin
      mis++;
      $display("FAIL t4_gap got s=%0d d=%h set=%b want 5 0035 1",
               skew, delay, set_d);
    end
  endtask

  task automatic test_realign();
    do_resync();
    step(4'hf, 4'h0, 1'b1);
    step(4'h0, 4'h0, 1'b1);
    step(4'h0, 4'b0001, 1'b1);
    step(4'h0, 4'b0110, 1'b1);
    cmp++;
    if (realign !== 1'b0 || done !== 1'b1) begin
      mis++;
      $display("FAIL t5_two got r=%b done=%b want 0 1", realign, done);
    end
    step(4'h0, 4'b0001, 1'b1);
    cmp++;
    if (realign !== 1'b1 || done !== 1'b0 || rd !== 1'b0) begin
      mis++;
      $display("FAIL t5_three got r=%b done=%b rd=%b want 1 0 0",
               realign, done, rd);
    end
    step(4'h0, 4'h0, 1'b1);
    cmp++;
    if (realign !== 1'b0) begin
      mis++;
      $display("FAIL t5_pulse got r=%b want 0", realign);
    end
    step(4'hf, 4'h0, 1'b1);
    step(4'h0, 4'h0, 1'b1);
    step(4'h0, 4'b0001, 1'b1);
    step(4'h0, 4'b1111, 1'b1);
    step(4'h0, 4'b0001, 1'b1);
    step(4'h0, 4'b1000, 1'b1);
    step(4'h0, 4'b0000, 1'b1);
    step(4'h0, 4'b0000, 1'b1);
    cmp++;
    if (realign !== 1'b0 || done !== 1'b1) begin
      mis++;
      $display("FAIL t5_pfp got r=%b done=%b want 0 1", realign, done);
    end
    step(4'h0, 4'b0100, 1'b1);
    cmp++;
    if (realign !== 1'b1 || done !== 1'b0) begin
      mis++;
      $display("FAIL t5_hold got r=%b done=%b want 1 0", realign, done);
    end
  endtask

  task automatic test_reset_mid();
    step(4'b0001, 4'h0, 1'b1);
    step(4'b0000, 4'h0, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    cmp++;
    if ({delay, skew, arrived, wr, done} !== 26'h0) begin
      mis++;
      $display("FAIL t6_async got %h want 0",
               {delay, skew, arrived, wr, done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(4'b1010, 4'h0, 1'b1);
    step(4'b0101, 4'h0, 1'b1);
    step(4'b0000, 4'h0, 1'b1);
    cmp++;
    if (skew !== 4'd1 || delay !== 16'h1010 || done !== 1'b1) begin
      mis++;
      $display("FAIL t6_remeas got s=%0d d=%h done=%b want 1 1010 1",
               skew, delay, done);
    end
    lock = 1'b0;
    step(4'h0, 4'h0, 1'b1);
    cmp++;
    if ({done, wr, rd} !== 3'b0 || arrived !== 4'h0 || skew !== 4'd1) begin
      mis++;
      $display("FAIL t6_lock got c=%b m=%h s=%0d want 000 0 1",
               {done, wr, rd}, arrived, skew);
    end
    step(4'hf, 4'h0, 1'b1);
    lock = 1'b1;
    step(4'hf, 4'h0, 1'b1);
    step(4'h0, 4'h0, 1'b1);
    cmp++;
    if (skew !== 4'd0 || delay !== 16'h0 || done !== 1'b1) begin
      mis++;
      $display("FAIL t6_relock got s=%0d d=%h done=%b want 0 0 1",
               skew, delay, done);
    end
  endtask

  initial begin
    test_reset();
    test_skew5();
    test_all_same();
    test_invalid();
    test_valid_gap();
    test_realign();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end

endmodule
